// File: rtl/fpu_pkg.sv
// Shared FPU types: IEEE-754 single-precision field widths and the operand-pair record.
// fop_t holds one queued multiply: both operands, destination tag and zero-operand hint.
// Pure declarations, no logic.
package fpu_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_W      = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FPU_TAG_W = 5;

  typedef struct packed {
    logic [FP_W-1:0]      x1;
    logic [FP_W-1:0]      x2;
    logic [FPU_TAG_W-1:0] tag;
    logic                 zero;
  } fop_t;
endpackage

// File: rtl/fop_screen.sv
// Operand screen for fmul: flushes zero-exponent operands to signed zero and flags them.
// Latency: purely combinational. Backpressure: none, sits on the enqueue path only.
// FMUL_OPQ_FTZ_EN enables screening; without it operands pass through and zero is 0.
module fop_screen
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] i_x1,
  input  logic [FP_W-1:0] i_x2,
  output logic [FP_W-1:0] o_x1,
  output logic [FP_W-1:0] o_x2,
  output logic            o_zero
);
`ifdef FMUL_OPQ_FTZ_EN
  logic w_z1;
  logic w_z2;

  // A zero exponent field covers both true zero and denormals; fmul handles neither.
  assign w_z1   = (i_x1[FP_W-2 -: FP_EXP_W] == '0);
  assign w_z2   = (i_x2[FP_W-2 -: FP_EXP_W] == '0);
  assign o_x1   = w_z1 ? {i_x1[FP_W-1], {(FP_W-1){1'b0}}} : i_x1;
  assign o_x2   = w_z2 ? {i_x2[FP_W-1], {(FP_W-1){1'b0}}} : i_x2;
  assign o_zero = w_z1 | w_z2;
`else
  assign o_x1   = i_x1;
  assign o_x2   = i_x2;
  assign o_zero = 1'b0;
`endif
endmodule

// File: rtl/fmul_opq.sv
// Operand queue feeding fmul: head pair in an output register, the rest in a circular buffer.
// Latency: enqueue into an empty queue is visible one cycle later; 1 pair/cycle streaming.
// Backpressure: in_ready drops only when all DEPTH entries are held; no full pass-through.
// FMUL_OPQ_FTZ_EN selects flush-to-zero screening and a live out_zero hint.
module fmul_opq
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5   // must match FPU_TAG_W, the tag width stored in fop_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FP_W-1:0]          in_x1,
  input  logic [FP_W-1:0]          in_x2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FP_W-1:0]          out_x1,
  output logic [FP_W-1:0]          out_x2,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BUF_N = DEPTH - 1;
  localparam int PW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_N - 1);

  // Buffer pointers wrap at BUF_N, which need not be a power of two.
  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  fop_t            r_head;
  fop_t            r_mem [BUF_N];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [FP_W-1:0] w_sx1;
  logic [FP_W-1:0] w_sx2;
  logic            w_szero;
  fop_t            w_new;
  logic            w_enq;
  logic            w_deq;
  logic            w_buf_has;
  logic            w_head_from_buf;
  logic            w_head_from_in;
  logic            w_buf_wr;

  fop_screen u_screen (
    .i_x1   (in_x1),
    .i_x2   (in_x2),
    .o_x1   (w_sx1),
    .o_x2   (w_sx2),
    .o_zero (w_szero)
  );

  assign w_new = {w_sx1, w_sx2, in_tag, w_szero};

  // The head register is loaded whenever anything is queued, so occupancy alone gives valid.
  assign out_valid = (r_count != '0);
  assign in_ready  = (r_count < CW'(DEPTH)) && !rst;
  assign w_enq     = in_valid && in_ready;
  assign w_deq     = out_valid && out_ready;
  assign w_buf_has = (r_count > CW'(1));

  // Head refills from the buffer first; a new pair goes straight to the head only when
  // nothing else is ahead of it, otherwise it lands in the buffer.
  assign w_head_from_buf = w_deq && w_buf_has;
  assign w_head_from_in  = w_enq && (!out_valid || (w_deq && !w_buf_has));
  assign w_buf_wr        = w_enq && !w_head_from_in;

  assign out_x1   = r_head.x1;
  assign out_x2   = r_head.x2;
  assign out_tag  = r_head.tag;
  assign out_zero = r_head.zero;
  assign count    = r_count;

  // Head register: holds steady unless a dequeue or a fill-from-empty happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (!flush) begin
      if (w_head_from_buf)
        r_head <= r_mem[r_rptr];
      else if (w_head_from_in)
        r_head <= w_new;
    end
  end

  // Buffer storage: data only, occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (w_buf_wr && !flush)
      r_mem[r_wptr] <= w_new;
  end

  // Occupancy and pointers; flush wins over any same-cycle enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_buf_wr)
        r_wptr <= f_ptr_inc(r_wptr);
      if (w_head_from_buf)
        r_rptr <= f_ptr_inc(r_rptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fmul_opq.sv
// Directed self-checking bench for fmul_opq: reset, latency, full/ordering, streaming,
// flush, mid-run reset and operand screening (expectations follow FMUL_OPQ_FTZ_EN).
module tb_fmul_opq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x1 = '0;
  logic [31:0] in_x2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x1;
  logic [31:0] out_x2;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fmul_opq #(.DEPTH(4), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x1    (out_x1),
    .out_x2    (out_x2),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .count     (count)
  );

  // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_x1 = 32'h12345678; in_x2 = 32'h9ABCDEF0; in_tag = 5'd9;
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d want=0", count); end
    n_cmp++; if (out_x1 !== 32'h0 || out_x2 !== 32'h0) begin n_err++; $display("FAIL rst_out_x got=%h/%h want=0/0", out_x1, out_x2); end
    n_cmp++; if (out_tag !== 5'd0 || out_zero !== 1'b0) begin n_err++; $display("FAIL rst_tag_zero got=%0d/%b want=0/0", out_tag, out_zero); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    in_valid = 1'b1; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 5'd3;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_x1 !== 32'h3F800000 || out_x2 !== 32'h40000000) begin n_err++; $display("FAIL single_x got=%h/%h want=3f800000/40000000", out_x1, out_x2); end
    n_cmp++; if (out_tag !== 5'd3 || out_zero !== 1'b0) begin n_err++; $display("FAIL single_tag_zero got=%0d/%b want=3/0", out_tag, out_zero); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got=%0d want=1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%0d/%b want=0/0", count, out_valid); end
  endtask

  task automatic test_full_order();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_x1 = 32'h40400000 + i; in_x2 = 32'h3F000000 + i; in_tag = 5'(10 + i);
      step();
    end
    in_x1 = 32'h41000000; in_x2 = 32'h41000000; in_tag = 5'd31;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d want=4", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    step();
    n_cmp++; if (count !== 3'd4 || out_tag !== 5'd10) begin n_err++; $display("FAIL full_5th_rejected got=%0d/%0d want=4/10", count, out_tag); end
    out_ready = 1'b1;
    n_cmp++; if (out_x1 !== 32'h40400000) begin n_err++; $display("FAIL full_head0 got=%h want=40400000", out_x1); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL full_deq_only got=%0d want=3", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen got=%b want=1", in_ready); end
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_x1 !== 32'h40400000 + k || out_x2 !== 32'h3F000000 + k || out_tag !== 5'(10 + k)) begin
        n_err++; $display("FAIL full_order%0d got=%b %h %h %0d want=1 %h %h %0d", k, out_valid, out_x1, out_x2, out_tag, 32'h40400000 + k, 32'h3F000000 + k, 10 + k);
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got=%0d/%b want=0/0", count, out_valid); end
  endtask

  task automatic test_stream();
    logic [68:0] q[$];
    logic [68:0] exp_v;
    logic        enq;
    logic        deq;
    int          seq = 0;
    int          n_deq = 0;
    for (int c = 0; c < 130; c++) begin
      if (c < 12) begin in_valid = 1'b1; out_ready = 1'b1; end
      else if (c < 110) begin in_valid = (c % 5 != 4); out_ready = (c % 3 != 0); end
      else begin in_valid = 1'b0; out_ready = 1'b1; end
      in_x1 = 32'h3F000000 | 32'(seq); in_x2 = 32'h41000000 + 32'(seq); in_tag = 5'(seq);
      if (c >= 1 && c < 12) begin
        n_cmp++; if (out_valid !== 1'b1 || count !== 3'd1) begin n_err++; $display("FAIL stream_rate c=%0d got=%b/%0d want=1/1", c, out_valid, count); end
      end
      enq = in_valid && in_ready;
      deq = out_valid && out_ready;
      if (deq) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stream_spurious c=%0d got=%h want=none", c, {out_x1, out_x2, out_tag});
        end else begin
          exp_v = q.pop_front();
          n_deq++;
          if ({out_x1, out_x2, out_tag} !== exp_v) begin n_err++; $display("FAIL stream_data c=%0d got=%h want=%h", c, {out_x1, out_x2, out_tag}, exp_v); end
        end
      end
      if (enq) begin q.push_back({in_x1, in_x2, in_tag}); seq++; end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (q.size() != 0 || count !== 3'd0) begin n_err++; $display("FAIL stream_leftover got=%0d/%0d want=0/0", q.size(), count); end
    n_cmp++; if (n_deq < 60) begin n_err++; $display("FAIL stream_volume got=%0d want>=60", n_deq); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x1 = 32'h42000000 + i; in_x2 = 32'h3F800000; in_tag = 5'(20 + i);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL flush_pre_count got=%0d want=2", count); end
    flush = 1'b1; in_valid = 1'b1; in_x1 = 32'h45000000; in_tag = 5'd30; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got=%0d/%b want=0/0", count, out_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d got=%b tag=%0d want=0", k, out_valid, out_tag); end
    end
    in_valid = 1'b1; in_x1 = 32'h46000000; in_x2 = 32'h40000000; in_tag = 5'd25;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 5'd25 || out_x1 !== 32'h46000000) begin n_err++; $display("FAIL flush_after got=%b/%0d/%h want=1/25/46000000", out_valid, out_tag, out_x1); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_after_drain got=%0d want=0", count); end
  endtask

  task automatic test_ftz();
    logic [31:0] exp_x1;
    logic        exp_z;
`ifdef FMUL_OPQ_FTZ_EN
    exp_x1 = 32'h80000000; exp_z = 1'b1;
`else
    exp_x1 = 32'h80000001; exp_z = 1'b0;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1; in_x1 = 32'h80000001; in_x2 = 32'h3F800000; in_tag = 5'd7;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_x1 !== exp_x1 || out_x2 !== 32'h3F800000) begin n_err++; $display("FAIL ftz_x1 got=%h/%h want=%h/3f800000", out_x1, out_x2, exp_x1); end
    n_cmp++; if (out_zero !== exp_z) begin n_err++; $display("FAIL ftz_zero1 got=%b want=%b", out_zero, exp_z); end
    out_ready = 1'b1; in_valid = 1'b1; in_x1 = 32'h40000000; in_x2 = 32'h00000000; in_tag = 5'd8;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_x1 !== 32'h40000000 || out_x2 !== 32'h0 || out_tag !== 5'd8) begin n_err++; $display("FAIL ftz_pair2 got=%h/%h/%0d want=40000000/0/8", out_x1, out_x2, out_tag); end
    n_cmp++; if (out_zero !== exp_z) begin n_err++; $display("FAIL ftz_zero2 got=%b want=%b", out_zero, exp_z); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL ftz_drain got=%0d want=0", count); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x1 = 32'h43000000 + i; in_x2 = 32'h3F800000; in_tag = 5'(i + 1);
      step();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mrst_pre_count got=%0d want=3", count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mrst_in_ready got=%b want=0", in_ready); end
    step();
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_clear got=%0d/%b want=0/0", count, out_valid); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_release got=%b want=1", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mrst_ghost got=%b/%0d want=0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_stream();
    test_flush();
    test_ftz();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fmul_opq.md
# fmul_opq

Operand queue directly upstream of the combinational single-precision multiplier (`fmul`). It buffers operand pairs from the FPU issue logic behind a valid/ready handshake. It presents one registered pair at a time to `fmul`'s `x1`/`x2` inputs, together with a zero-operand hint. `fmul` has no zero/denormal handling, so downstream logic uses `out_zero` to force a signed-zero result.

## Interface
- `DEPTH`, 4: total entries, including the output register; power of two, ≥2
- `TAG_W`, 5: width of the destination tag carried alongside each pair
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `flush`  in  1  discard all queued entries
- `in_valid`  in  1  upstream offers a pair
- `in_ready`  out  1  queue accepts a pair this cycle
- `in_x1`, `in_x2`  in  32  IEEE-754 single operands
- `in_tag`  in  TAG_W  destination tag
- `out_valid`  out  1  head pair valid
- `out_ready`  in  1  consumer takes head this cycle
- `out_x1`, `out_x2`  out  32  operands to `fmul`
- `out_tag`  out  TAG_W  tag of head
- `out_zero`  out  1  either head operand is zero/denormal
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- enq = `in_valid && in_ready`; deq = `out_valid && out_ready`.
- `in_ready` = (`count` < `DEPTH`) && !`rst`. There is no pass-through when full: a same-cycle deq does not raise `in_ready`.
- FIFO order is strict. The head always sits in the output register, and the remaining entries sit in a circular buffer with read/write pointers that wrap modulo DEPTH-1.
- On deq, the next buffered entry (or an entry enqueued this cycle, if the buffer is empty) loads the output register.
- `count` changes by +1 on enq, -1 on deq, and is unchanged when both occur.
- `flush` takes priority over enq and deq in the same cycle. It sets count=0, out_valid=0 and resets both pointers. A pair offered in a flush cycle is dropped, but `in_ready` still reads as normally computed.
- Operand screening is done per entry at enqueue time. Results are stored with the entry, so screening never sits on the output path.
- Outputs stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: out_valid=0, out_x1=0, out_x2=0, out_tag=0, out_zero=0, count=0, pointers=0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Latency: an enq into an empty queue at cycle t gives out_valid=1 at t+1.
- Throughput is 1 pair/cycle when `out_ready` is held high and no flush occurs.
- When `rst` is asserted mid-operation, all entries are lost with no partial output.

## Configuration
- `FMUL_OPQ_FTZ_EN` defined:
  - An operand whose exponent field is 0 is replaced by signed zero (sign kept, exponent and mantissa cleared).
  - `out_zero` = either stored operand has exponent 0.
- `FMUL_OPQ_FTZ_EN` undefined:
  - Operands pass through unmodified.
  - `out_zero` is tied to 0, and the screening logic and its storage bit are removed.

## Structure
- Shared package `fpu_pkg` holds:
  - Constants `FP_EXP_W=8` and `FP_MAN_W=23`.
  - Typedef `fop_t` (`x1`, `x2`, `tag`, `zero`), with TAG_W fixed by a package constant `FPU_TAG_W`.
- One combinational sub-module, `fop_screen`, takes two operands and returns the screened operands and the `zero` flag. It is instantiated once, on the enqueue path.

## Test plan
- Reset with `in_valid`=1 → in_ready=0 and out_valid=0 during `rst`; in_ready=1 in the first cycle after.
- Empty queue, enq x1=0x3F800000, x2=0x40000000, tag=3 → next cycle out_valid=1 with the same values, out_zero=0, count=1.
- `out_ready`=0, enq 4 pairs → count=4, in_ready=0. A 5th offer is not accepted. Then hold `out_ready`=1 → the 4 pairs emerge in order on consecutive cycles.
- Full queue with simultaneous in_valid and out_ready → deq only, count=3, and in_ready=1 the next cycle. Also cover continuous streaming with pointers wrapping ≥3 times and no loss or reordering.
- `flush` in the same cycle as enq and deq with count=2 → next cycle count=0 and out_valid=0, and the offered pair does not appear later.
- FTZ defined: x1=0x80000001, x2=0x3F800000 → out_x1=0x80000000, out_zero=1. FTZ undefined: the same input gives out_x1=0x80000001, out_zero=0.
